// File: rtl/spike_synapse.sv
// Pre-synaptic stage: turns upstream spike edges into a weighted, exponentially
// decaying current trace that feeds a neuron's 8-bit current input.
module spike_synapse #(
    parameter int unsigned DECAY_PERIOD   = 16,
    parameter int unsigned DECAY_SHIFT    = 3,
    parameter logic [7:0]  DEFAULT_WEIGHT = 8'd40
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spike_in,
    input  logic [7:0] weight_in,
    input  logic       weight_load,
    input  logic [7:0] bias,
    input  logic       count_clr,
    output logic [7:0] current,
    output logic       event_pulse,
    output logic [7:0] event_count,
    output logic       active,
    output logic [7:0] weight
);

    localparam int unsigned PW = $clog2(DECAY_PERIOD);
    localparam int unsigned SW = 10;

    logic [PW-1:0] prescaler;
    logic          spike_q;
    logic [7:0]    trace;

    logic          rise;
    logic          tick;
    logic [7:0]    shifted;
    logic [7:0]    dec;
    logic [7:0]    inc;
    logic [SW-1:0] sum;
    logic [7:0]    trace_next;
    logic [SW-1:0] cur_sum;
    logic [7:0]    current_next;

    assign rise    = spike_in & ~spike_q;
    assign tick    = (prescaler == PW'(DECAY_PERIOD - 1));
    assign shifted = trace >> DECAY_SHIFT;
    assign active  = (trace != 8'd0);

    // Decay first (at least 1 LSB so the tail reaches zero), then add weight.
    always_comb begin
        dec = 8'd0;
        if (tick) begin
            if (shifted != 8'd0)
                dec = shifted;
            else if (trace != 8'd0)
                dec = 8'd1;
        end
        inc          = rise ? weight : 8'd0;
        sum          = SW'(trace) - SW'(dec) + SW'(inc);
        trace_next   = (sum > SW'(255)) ? 8'd255 : sum[7:0];
        cur_sum      = SW'(trace_next) + SW'(bias);
        current_next = (cur_sum > SW'(255)) ? 8'd255 : cur_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prescaler   <= '0;
            spike_q     <= 1'b0;
            trace       <= 8'd0;
            current     <= 8'd0;
            event_pulse <= 1'b0;
            event_count <= 8'd0;
            weight      <= DEFAULT_WEIGHT;
        end else begin
            prescaler   <= tick ? '0 : prescaler + PW'(1);
            spike_q     <= spike_in;
            trace       <= trace_next;
            current     <= current_next;
            event_pulse <= rise;
            if (count_clr)
                event_count <= 8'd0;
            else if (rise && event_count != 8'hFF)
                event_count <= event_count + 8'd1;
            if (weight_load)
                weight <= weight_in;
        end
    end

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse: a cycle-level arithmetic model checked every
// cycle, plus hand-computed literal expectations from the test plan.
module tb_spike_synapse;

    localparam int P = 16;
    localparam int S = 3;

    logic       clk;
    logic       reset_n;
    logic       spike_in;
    logic [7:0] weight_in;
    logic       weight_load;
    logic [7:0] bias;
    logic       count_clr;
    logic [7:0] current;
    logic       event_pulse;
    logic [7:0] event_count;
    logic       active;
    logic [7:0] weight;

    spike_synapse dut (
        .clk(clk), .reset_n(reset_n), .spike_in(spike_in),
        .weight_in(weight_in), .weight_load(weight_load), .bias(bias),
        .count_clr(count_clr), .current(current), .event_pulse(event_pulse),
        .event_count(event_count), .active(active), .weight(weight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: plain integers, time measured in cycles since reset release.
    int m_trace, m_cur, m_ev, m_cnt, m_w, m_prev, m_cyc;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int rise, dec, t, c;
        if (!reset_n) begin
            m_trace = 0; m_cur = 0; m_ev = 0; m_cnt = 0; m_w = 40; m_prev = 0; m_cyc = 0;
        end else begin
            rise = (spike_in && !m_prev) ? 1 : 0;
            dec = 0;
            if ((m_cyc % P) == P - 1 && m_trace != 0) begin
                dec = m_trace / (1 << S);
                if (dec == 0) dec = 1;
            end
            m_cyc++;
            t = m_trace - dec + (rise ? m_w : 0);
            m_trace = (t > 255) ? 255 : t;
            c = m_trace + int'(bias);
            m_cur = (c > 255) ? 255 : c;
            m_ev = rise;
            if (count_clr) m_cnt = 0;
            else if (rise && m_cnt < 255) m_cnt++;
            if (weight_load) m_w = int'(weight_in);
            m_prev = spike_in ? 1 : 0;
        end
    endtask

    // One clock: advance model at the edge, compare all outputs 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("model_current", int'(current), m_cur);
        chk("model_event", int'(event_pulse), m_ev);
        chk("model_event_count", int'(event_count), m_cnt);
        chk("model_active", int'(active), (m_trace != 0) ? 1 : 0);
        chk("model_weight", int'(weight), m_w);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        cycles(n);
        reset_n = 1'b1;
    endtask

    // Run until current changes; n = cycles taken, bounded.
    task automatic run_until_change(input string name, output int n);
        logic [7:0] prev;
        prev = current;
        n = 0;
        for (int i = 1; i <= 3 * P; i++) begin
            cyc();
            if (current != prev) begin
                n = i;
                return;
            end
        end
        chk({name, "_timeout"}, 1, 0);
    endtask

    initial begin
        int n;
        reset_n = 1'b0; spike_in = 1'b0; weight_in = 8'd0; weight_load = 1'b0;
        bias = 8'd0; count_clr = 1'b0;

        // 1: reset with spike held and a load attempt
        spike_in = 1'b1; weight_load = 1'b1; weight_in = 8'd99;
        cycles(3);
        chk("rst_current", int'(current), 0);
        chk("rst_event", int'(event_pulse), 0);
        chk("rst_count", int'(event_count), 0);
        chk("rst_active", int'(active), 0);
        chk("rst_weight", int'(weight), 40);
        weight_load = 1'b0; reset_n = 1'b1;
        cyc();
        chk("rel_event", int'(event_pulse), 1);
        chk("rel_current", int'(current), 40);
        cycles(3);
        chk("held_no_event", int'(event_pulse), 0);
        chk("held_count", int'(event_count), 1);
        spike_in = 1'b0;

        // 2: single spike and decay sequence
        do_reset(3);
        spike_in = 1'b1;
        cyc();
        chk("s2_event", int'(event_pulse), 1);
        chk("s2_current", int'(current), 40);
        cycles(2);
        spike_in = 1'b0;
        run_until_change("s2_d1", n); chk("s2_decay1", int'(current), 35);
        run_until_change("s2_d2", n); chk("s2_decay2", int'(current), 31);
        chk("s2_period", n, P);
        run_until_change("s2_d3", n); chk("s2_decay3", int'(current), 28);
        run_until_change("s2_d4", n); chk("s2_decay4", int'(current), 25);

        // 3: saturation
        do_reset(2);
        weight_load = 1'b1; weight_in = 8'd200;
        cyc();
        weight_load = 1'b0; spike_in = 1'b1;
        cyc();
        chk("s3_first", int'(current), 200);
        spike_in = 1'b0;
        cycles(2);
        spike_in = 1'b1;
        cyc();
        chk("s3_sat", int'(current), 255);
        chk("s3_count", int'(event_count), 2);
        spike_in = 1'b0;

        // 4: decay tail from 3
        do_reset(2);
        weight_load = 1'b1; weight_in = 8'd3;
        cyc();
        weight_load = 1'b0; spike_in = 1'b1;
        cyc();
        spike_in = 1'b0;
        chk("s4_start", int'(current), 3);
        run_until_change("s4_t1", n); chk("s4_tail1", int'(current), 2);
        run_until_change("s4_t2", n); chk("s4_tail2", int'(current), 1);
        chk("s4_active_hi", int'(active), 1);
        run_until_change("s4_t3", n); chk("s4_tail3", int'(current), 0);
        chk("s4_active_lo", int'(active), 0);
        cycles(2 * P);
        chk("s4_stays0", int'(current), 0);

        // 5: bias and collisions
        do_reset(2);
        bias = 8'd250;
        cyc();
        chk("s5_bias_only", int'(current), 250);
        spike_in = 1'b1;
        cyc();
        chk("s5_bias_sat", int'(current), 255);
        spike_in = 1'b0; bias = 8'd0;
        do_reset(2);
        spike_in = 1'b1; weight_load = 1'b1; weight_in = 8'd100;
        cyc();
        chk("s5_old_weight", int'(current), 40);
        chk("s5_new_weight", int'(weight), 100);
        spike_in = 1'b0; weight_load = 1'b0;
        cyc();
        spike_in = 1'b1;
        cyc();
        chk("s5_next_edge", int'(current), 140);
        spike_in = 1'b0;
        cyc();
        spike_in = 1'b1; count_clr = 1'b1;
        cyc();
        chk("s5_clr_event", int'(event_pulse), 1);
        chk("s5_clr_count", int'(event_count), 0);
        chk("s5_clr_current", int'(current), 240);
        spike_in = 1'b0; count_clr = 1'b0;

        // 6: mid-operation reset, prescaler restart
        do_reset(1);
        weight_load = 1'b1; weight_in = 8'd120;
        cyc();
        weight_load = 1'b0; spike_in = 1'b1;
        cyc();
        chk("s6_trace", int'(current), 120);
        spike_in = 1'b0;
        cycles(5);
        spike_in = 1'b1;
        do_reset(1);
        chk("s6_rst_current", int'(current), 0);
        chk("s6_rst_active", int'(active), 0);
        chk("s6_rst_count", int'(event_count), 0);
        chk("s6_rst_event", int'(event_pulse), 0);
        chk("s6_rst_weight", int'(weight), 40);
        cyc();
        chk("s6_rel_current", int'(current), 40);
        run_until_change("s6_tick", n);
        chk("s6_first_tick_at", n + 1, P);
        chk("s6_decayed", int'(current), 35);
        spike_in = 1'b0;
        cycles(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
